// File: rtl/cpu_pkg.sv
// Shared opcodes, state encoding and control bundle for the control unit.
// Build option MULDIV_EN enables the mul/div execute sequence.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

`ifdef MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  typedef enum logic [3:0] {
    RESET_ST, T0, T1, T2, T3,
    T4, T5, T6, T7, HALT
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic inc_pc;
    logic pc_en;
    logic mar_en;
    logic mdr_en;
    logic mdr_rd;
    logic mdr_out;
    logic ir_en;
    logic ram_wr;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic c_out;
    logic y_en;
    logic zlo_in;
    logic zhi_in;
    logic zlo_out;
    logic zhi_out;
    logic hi_en;
    logic lo_en;
    logic hi_out;
    logic lo_out;
    logic inport_out;
    logic outport_en;
    logic con_in;
  } ctrl_t;

  function automatic logic is_alu3(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_mem(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_short(input logic [4:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_IN) || (op == OP_OUT);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return MULDIV_ON && ((op == OP_MUL) || (op == OP_DIV));
  endfunction

  function automatic logic has_exec(input logic [4:0] op);
    return is_alu3(op) || is_mem(op) || is_short(op) ||
           is_muldiv(op) || (op == OP_ADDI) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore decoder: (state, opcode) -> datapath control vector.
// Everything not named for a state stays 0.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     state_i,
  input  logic [4:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic [4:0] alu_op_o,
  output logic       run_o
);

  logic a3, mem, ldi, addi, mdv;

  assign a3   = is_alu3(opcode_i);
  assign mem  = is_mem(opcode_i);
  assign ldi  = (opcode_i == OP_LDI);
  assign addi = (opcode_i == OP_ADDI);
  assign mdv  = is_muldiv(opcode_i);

  // decode control strobes for the current state
  always_comb begin
    ctrl_o   = '0;
    alu_op_o = ALU_ADD;
    run_o    = (state_i != HALT);
    unique case (state_i)
      RESET_ST, HALT: ;
      T0: begin
        ctrl_o.pc_out = 1'b1;
        ctrl_o.mar_en = 1'b1;
        ctrl_o.inc_pc = 1'b1;
        ctrl_o.zlo_in = 1'b1;
      end
      T1: begin
        ctrl_o.zlo_out = 1'b1;
        ctrl_o.pc_en   = 1'b1;
        ctrl_o.mdr_rd  = 1'b1;
        ctrl_o.mdr_en  = 1'b1;
      end
      T2: begin
        ctrl_o.mdr_out = 1'b1;
        ctrl_o.ir_en   = 1'b1;
      end
      T3: begin
        if (a3 || addi) begin
          ctrl_o.grb   = 1'b1;
          ctrl_o.r_out = 1'b1;
          ctrl_o.y_en  = 1'b1;
        end else if (mem || ldi) begin
          ctrl_o.grb    = 1'b1;
          ctrl_o.ba_out = 1'b1;
          ctrl_o.y_en   = 1'b1;
        end else if (mdv) begin
          ctrl_o.gra   = 1'b1;
          ctrl_o.r_out = 1'b1;
          ctrl_o.y_en  = 1'b1;
        end else if (opcode_i == OP_MFHI) begin
          ctrl_o.gra    = 1'b1;
          ctrl_o.r_in   = 1'b1;
          ctrl_o.hi_out = 1'b1;
        end else if (opcode_i == OP_MFLO) begin
          ctrl_o.gra    = 1'b1;
          ctrl_o.r_in   = 1'b1;
          ctrl_o.lo_out = 1'b1;
        end else if (opcode_i == OP_IN) begin
          ctrl_o.gra        = 1'b1;
          ctrl_o.r_in       = 1'b1;
          ctrl_o.inport_out = 1'b1;
        end else if (opcode_i == OP_OUT) begin
          ctrl_o.gra        = 1'b1;
          ctrl_o.r_out      = 1'b1;
          ctrl_o.outport_en = 1'b1;
        end
      end
      T4: begin
        if (a3) begin
          ctrl_o.grc    = 1'b1;
          ctrl_o.r_out  = 1'b1;
          ctrl_o.zlo_in = 1'b1;
          alu_op_o      = opcode_i;
        end else if (addi || mem || ldi) begin
          ctrl_o.c_out  = 1'b1;
          ctrl_o.zlo_in = 1'b1;
        end else if (mdv) begin
          ctrl_o.grb    = 1'b1;
          ctrl_o.r_out  = 1'b1;
          ctrl_o.zlo_in = 1'b1;
          ctrl_o.zhi_in = 1'b1;
          alu_op_o      = opcode_i;
        end
      end
      T5: begin
        if (a3 || addi || ldi) begin
          ctrl_o.zlo_out = 1'b1;
          ctrl_o.gra     = 1'b1;
          ctrl_o.r_in    = 1'b1;
        end else if (mem) begin
          ctrl_o.zlo_out = 1'b1;
          ctrl_o.mar_en  = 1'b1;
        end else if (mdv) begin
          ctrl_o.zlo_out = 1'b1;
          ctrl_o.lo_en   = 1'b1;
        end
      end
      T6: begin
        if (opcode_i == OP_LD) begin
          ctrl_o.mdr_rd = 1'b1;
          ctrl_o.mdr_en = 1'b1;
        end else if (opcode_i == OP_ST) begin
          ctrl_o.gra    = 1'b1;
          ctrl_o.r_out  = 1'b1;
          ctrl_o.mdr_en = 1'b1;
        end else if (mdv) begin
          ctrl_o.zhi_out = 1'b1;
          ctrl_o.hi_en   = 1'b1;
        end
      end
      T7: begin
        if (opcode_i == OP_LD) begin
          ctrl_o.mdr_out = 1'b1;
          ctrl_o.gra     = 1'b1;
          ctrl_o.r_in    = 1'b1;
        end else if (opcode_i == OP_ST) begin
          ctrl_o.ram_wr = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU sequencer: state register, next-state and stop-pending.
// Build option MULDIV_EN (see cpu_pkg) adds the mul/div sequence.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic [4:0]  alu_op,
  output logic        PCout,
  output logic        IncPC,
  output logic        PC_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        MDR_read,
  output logic        MDRout,
  output logic        IR_enable,
  output logic        RAM_write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        BAout,
  output logic        Cout,
  output logic        Y_enable,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        OutPort_enable,
  output logic        CONin
);

  state_t     state_q, state_d;
  logic       stop_q, stop_d;
  logic [4:0] op;
  ctrl_t      ctrl;
  logic       unused_in;

  assign op        = IR[31:27];
  assign unused_in = ^{CON_FF, IR[26:0]};

  // state and stop-pending registers
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= RESET_ST;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  // next state; a pending stop diverts the next T0 entry to HALT
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q | Stop;
    unique case (state_q)
      RESET_ST: state_d = T0;
      T0:       state_d = T1;
      T1:       state_d = T2;
      T2: begin
        if (op == OP_HALT)    state_d = HALT;
        else if (has_exec(op)) state_d = T3;
        else                  state_d = T0;
      end
      T3:   state_d = is_short(op) ? T0 : T4;
      T4:   state_d = T5;
      T5:   state_d = (is_mem(op) || is_muldiv(op)) ? T6 : T0;
      T6:   state_d = is_muldiv(op) ? T0 : T7;
      T7:   state_d = T0;
      HALT: state_d = HALT;
    endcase
    if (state_d == T0 && stop_d) state_d = HALT;
    if (state_d == HALT) stop_d = 1'b0;
  end

  ctrl_decode u_dec (
    .state_i  (state_q),
    .opcode_i (op),
    .ctrl_o   (ctrl),
    .alu_op_o (alu_op),
    .run_o    (Run)
  );

  assign PCout          = ctrl.pc_out;
  assign IncPC          = ctrl.inc_pc;
  assign PC_enable      = ctrl.pc_en;
  assign MAR_enable     = ctrl.mar_en;
  assign MDR_enable     = ctrl.mdr_en;
  assign MDR_read       = ctrl.mdr_rd;
  assign MDRout         = ctrl.mdr_out;
  assign IR_enable      = ctrl.ir_en;
  assign RAM_write      = ctrl.ram_wr;
  assign Gra            = ctrl.gra;
  assign Grb            = ctrl.grb;
  assign Grc            = ctrl.grc;
  assign R_in           = ctrl.r_in;
  assign R_out          = ctrl.r_out;
  assign BAout          = ctrl.ba_out;
  assign Cout           = ctrl.c_out;
  assign Y_enable       = ctrl.y_en;
  assign ZLowIn         = ctrl.zlo_in;
  assign ZHighIn        = ctrl.zhi_in;
  assign ZLowout        = ctrl.zlo_out;
  assign ZHighout       = ctrl.zhi_out;
  assign HI_enable      = ctrl.hi_en;
  assign LO_enable      = ctrl.lo_en;
  assign HIout          = ctrl.hi_out;
  assign LOout          = ctrl.lo_out;
  assign InPortout      = ctrl.inport_out;
  assign OutPort_enable = ctrl.outport_en;
  assign CONin          = ctrl.con_in;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Clock  in  1  single clock; all state updates occur on its rising edge.
REQ-003 Clear  in  1  asynchronous, active-high reset.
REQ-004 IR  in  32  instruction register contents; opcode is IR[31:27].
REQ-005 CON_FF  in  1  branch-condition flag from the datapath (sampled, unused in v1 sequences).
REQ-006 Stop  in  1  request to halt after the current instruction completes.
REQ-007 Run  out  1  high while not in HALT.
REQ-008 alu_op  out  5  ALU operation select; equals opcode during ALU-compute states, ADD (5'b00011) otherwise.
REQ-009 The following 1-bit control outputs SHALL drive the datapath: PCout, IncPC, PC_enable, MAR_enable, MDR_enable, MDR_read, MDRout, IR_enable, RAM_write, Gra, Grb, Grc, R_in, R_out, BAout, Cout, Y_enable, ZLowIn, ZHighIn, ZLowout, ZHighout, HI_enable, LO_enable, HIout, LOout, InPortout, OutPort_enable, CONin.

Function
REQ-010 The state register SHALL hold one of RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7 or HALT, advancing at most one state per rising Clock edge.
REQ-011 Control outputs SHALL be Moore-decoded from the state and IR[31:27]; any output not listed for a state SHALL be 0.
REQ-012 The transition RESET_ST -> T0 SHALL occur on the first edge after Clear deasserts.
REQ-013 Fetch states SHALL assert:
  - T0: PCout, MAR_enable, IncPC, ZLowIn.
  - T1: ZLowout, PC_enable, MDR_read, MDR_enable.
  - T2: MDRout, IR_enable.
REQ-014 Opcodes SHALL be: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01011, mul=01111, div=10000, in=10110, out=10111, mfhi=11000, mflo=11001, nop=11010, halt=11011.
REQ-015 The add/sub/and/or sequence SHALL assert:
  - T3: Grb, R_out, Y_enable.
  - T4: Grc, R_out, ZLowIn, with alu_op=opcode.
  - T5: ZLowout, Gra, R_in.
  - Next state: T0.
REQ-016 The addi sequence SHALL assert:
  - T3: Grb, R_out, Y_enable.
  - T4: Cout, ZLowIn, with alu_op=ADD.
  - T5: ZLowout, Gra, R_in.
  - Next state: T0.
REQ-017 The ld/ldi sequence SHALL assert:
  - T3: Grb, BAout, Y_enable.
  - T4: Cout, ZLowIn.
  - ldi T5: ZLowout, Gra, R_in, then T0.
  - ld T5: ZLowout, MAR_enable.
  - ld T6: MDR_read, MDR_enable.
  - ld T7: MDRout, Gra, R_in, then T0.
REQ-018 The st sequence SHALL follow ld through T5, then assert:
  - T6: Gra, R_out, MDR_enable, with MDR_read=0.
  - T7: RAM_write.
  - Next state: T0.
REQ-019 The mfhi/mflo sequence SHALL assert in T3: Gra, R_in, and HIout or LOout respectively; next state T0.
REQ-020 The in sequence SHALL assert in T3: Gra, R_in, InPortout. The out sequence SHALL assert in T3: Gra, R_out, OutPort_enable. Both SHALL proceed to T0 next.
REQ-021 nop and undefined opcodes SHALL go T2 -> T0 with no execute state.
REQ-022 A halt opcode SHALL go T2 -> HALT; HALT SHALL hold all control outputs at 0 and Run=0 until Clear.
REQ-023 Stop sampled high in any state SHALL cause the next T0 entry to become HALT instead; the current instruction SHALL complete.
REQ-024 Each instruction's latency SHALL be:
  - ALU/addi/ldi: 6 cycles.
  - ld/st: 8 cycles.
  - mfhi/mflo/in/out: 4 cycles.
  - nop: 3 cycles.

Reset
REQ-025 Clear high SHALL immediately force RESET_ST, all control outputs to 0, Run=1, alu_op=ADD, and a cleared stop-pending flag, regardless of the current state, including mid-instruction.

Configuration
REQ-026 With macro MULDIV_EN defined, the mul/div sequence SHALL assert:
  - T3: Gra, R_out, Y_enable.
  - T4: Grb, R_out, ZLowIn, ZHighIn, with alu_op=opcode.
  - T5: ZLowout, LO_enable.
  - T6: ZHighout, HI_enable.
  - Next state: T0.
REQ-027 Without MULDIV_EN, the mul and div opcodes SHALL behave exactly as nop.

Structure
REQ-028 A shared package cpu_pkg SHALL hold the opcode constants, the state enumeration type and ALU_ADD.
REQ-029 One sub-module, ctrl_decode, SHALL be the combinational (state, opcode) -> control-vector decoder; control_unit SHALL hold the state register, next-state logic and stop-pending flag.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - Release Clear, IR=32'h59080002 (addi) -> T0..T5 in 6 cycles; T4 has Cout=1 and ZLowIn=1; T5 has Gra=1, R_in=1, ZLowout=1.
  - IR=32'hC8000000 (mflo) -> T3 has Gra=1, R_in=1, LOout=1; T0 on the next edge.
  - IR opcode st -> T6 has MDR_enable=1 and MDR_read=0; T7 has RAM_write=1; every other output is 0 in T7.
  - Stop pulsed during T4 of add -> T5 completes, then HALT with Run=0 held for 10 cycles.
  - Clear asserted mid-T6 of ld -> all outputs 0 asynchronously before the next edge; T0 follows release.
  - IR opcode mul, built with and without MULDIV_EN -> HI_enable in T6 with the macro; T2 -> T0 without it.
